cnn_layer_accel_fetch_resp: RTL
===============================

# cnn_layer_accel_fetch_resp

Host-side responder for the `cnn_layer_accel_quad` job/fetch protocol, clocked in the interface domain. It accepts a job command (rows × cols), starts the job, and answers each `job_fetch_request` by acknowledging it and streaming exactly one input row of 8-channel pixel words from an upstream source. When the quad reports `job_complete`, it acknowledges and signals done upstream. It sits between the DMA/pixel source and the quad, replacing the bench-driven job sequencing.

## Interface
- C_PIXEL_WIDTH, 16, bits per channel pixel
- C_NUM_CH, 8, channels per pixel word; data width DW = C_PIXEL_WIDTH*C_NUM_CH (128)
- C_DIM_WIDTH, 10, width of row/col counts
- clk_if  in  1  interface clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_num_rows  in  C_DIM_WIDTH  rows in job (N = N rows)
- cmd_num_cols  in  C_DIM_WIDTH  pixels per row
- done  out  1  one-cycle pulse at job end
- done_err  out  1  qualifies done: zero-dimension command
- extra_fetch_err  out  1  sticky; fetch request seen after all rows were delivered; cleared on next cmd accept
- src_valid  in  1  source pixel valid
- src_ready  out  1  source pixel taken
- src_data  in  DW  source pixel word, channel k at [k*C_PIXEL_WIDTH +: C_PIXEL_WIDTH]
- job_start  out  1  to quad
- job_accept  in  1  from quad
- job_fetch_request  in  1  level, from quad
- job_fetch_ack  out  1  one-cycle pulse
- job_fetch_complete  out  1  one-cycle pulse
- job_complete  in  1  from quad
- job_complete_ack  out  1  one-cycle pulse
- pixel_valid  out  1  to quad
- pixel_ready  in  1  from quad
- pixel_data  out  DW  to quad

## Operation
- FSM states: IDLE, START, WAIT_REQ, ACK, STREAM, FCOMP, WAIT_DONE, CACK.
- IDLE: cmd_ready=1. On cmd accept, latch rows/cols, clear row_cnt, col_cnt, and extra_fetch_err. If rows==0 or cols==0: pulse done with done_err=1 next cycle, stay IDLE, touch no quad signal. Otherwise go to START.
- START: job_start=1 until job_accept is sampled high; job_start drops on the following cycle; go to WAIT_REQ.
- WAIT_REQ: on job_fetch_request=1, go to ACK.
- ACK: job_fetch_ack=1 for exactly one cycle; go to STREAM.
- STREAM: combinational pass-through: pixel_valid=src_valid, src_ready=pixel_ready, pixel_data=src_data. Outside STREAM, pixel_valid=0, src_ready=0, and pixel_data holds src_data.
- A beat transfers when pixel_valid & pixel_ready. col_cnt counts beats. On the beat where col_cnt == cols-1, go to FCOMP and clear col_cnt.
- FCOMP: job_fetch_complete=1 for one cycle; row_cnt++. If row_cnt reaches rows, go to WAIT_DONE; otherwise go to WAIT_REQ.
- WAIT_DONE: job_complete=1 goes to CACK. A job_fetch_request seen here sets extra_fetch_err and is not acked.
- CACK: job_complete_ack=1 for one cycle, done=1 in the same cycle, done_err=0; go to IDLE.
- Counters are C_DIM_WIDTH wide with no wrap: the maximum dimension is 2^C_DIM_WIDTH-1.

## Timing
- Reset values: all outputs 0 (cmd_ready=0 during reset, 1 the first cycle after release); state IDLE; counters 0.
- Reset is asynchronous. Asserting rst_n mid-job aborts immediately: job_start, pixel_valid, and all ack/complete pulses drop the same instant. No partial-row recovery.
- All outputs except pixel_valid/src_ready/pixel_data are registered.
- Cycle latencies:
  - cmd accept → job_start: 1 cycle.
  - job_fetch_request sampled → job_fetch_ack: 1 cycle.
  - ack → pixel_valid possible: next cycle.
  - Last beat → job_fetch_complete: next cycle.
  - job_complete sampled → job_complete_ack and done: next cycle.
- Minimum row overhead: 3 cycles (WAIT_REQ, ACK, FCOMP) plus cols beats.
- job_fetch_request being held high through ACK/STREAM/FCOMP is not a new request. A new request is recognised only in WAIT_REQ.
- job_complete arriving before WAIT_DONE is ignored. The quad holds it until acked.
- Stalls:
  - src_valid=0 or pixel_ready=0 stalls STREAM indefinitely with no timeout.
  - Data integrity is by pass-through; no word is dropped or duplicated.

## Test plan
- 10×10 job, src and quad always ready: exactly 10 fetch_ack and 10 fetch_complete pulses, 100 beats in source order; job_complete → job_complete_ack and done 1 cycle later with done_err=0.
- Same job with pixel_ready toggling 1/0 and src_valid random 50%: beat sequence unchanged; each fetch_complete occurs exactly 1 cycle after the 10th beat of its row.
- cmd rows=0, cols=5: done=1 and done_err=1 one cycle after accept; job_start never asserts; src_ready stays 0.
- job_accept delayed 7 cycles: job_start held high for 8 cycles, then drops; no ack is issued before the first fetch_request.
- 2×4 job, job_fetch_request raised again in WAIT_DONE: no ack; extra_fetch_err=1 and stays set through done; cleared on the next cmd accept.
- rst_n low for 1 cycle mid-row 3 (beat 4): all outputs 0 immediately, cmd_ready=1 after release; a new 3×3 job then completes normally with 9 beats.

Source files
------------

// File: rtl/cnn_layer_accel_fetch_resp.sv
`default_nettype none
// ============================================================================
// Module   : cnn_layer_accel_fetch_resp
// Brief    : Host-side job/fetch responder for cnn_layer_accel_quad; streams
//            one row of pixel words from the source per fetch request.
// Revision : 1.0 - initial release
// ============================================================================
module cnn_layer_accel_fetch_resp #(
    parameter int C_PIXEL_WIDTH = 16,
    parameter int C_NUM_CH      = 8,
    parameter int C_DIM_WIDTH   = 10,
    localparam int C_DW         = C_PIXEL_WIDTH * C_NUM_CH
) (
    input  logic                   clk_if,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [C_DIM_WIDTH-1:0] cmd_num_rows,
    input  logic [C_DIM_WIDTH-1:0] cmd_num_cols,
    output logic                   done,
    output logic                   done_err,
    output logic                   extra_fetch_err,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [C_DW-1:0]        src_data,
    output logic                   job_start,
    input  logic                   job_accept,
    input  logic                   job_fetch_request,
    output logic                   job_fetch_ack,
    output logic                   job_fetch_complete,
    input  logic                   job_complete,
    output logic                   job_complete_ack,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic [C_DW-1:0]        pixel_data
);

    localparam logic [C_DIM_WIDTH-1:0] C_ONE = {{(C_DIM_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_REQ  = 3'd2,
        S_ACK       = 3'd3,
        S_STREAM    = 3'd4,
        S_FCOMP     = 3'd5,
        S_WAIT_DONE = 3'd6,
        S_CACK      = 3'd7
    } state_t;

    state_t                 r_state;
    logic [C_DIM_WIDTH-1:0] r_rows;
    logic [C_DIM_WIDTH-1:0] r_cols;
    logic [C_DIM_WIDTH-1:0] r_row_cnt;
    logic [C_DIM_WIDTH-1:0] r_col_cnt;

    logic                   w_streaming;
    logic                   w_beat;
    logic [C_DIM_WIDTH-1:0] w_row_next;

    // Pixel path is a pure pass-through so no word can be dropped or duplicated.
    assign w_streaming = (r_state == S_STREAM);
    assign pixel_valid = w_streaming & src_valid;
    assign src_ready   = w_streaming & pixel_ready;
    assign pixel_data  = src_data;
    assign w_beat      = pixel_valid & pixel_ready;
    assign w_row_next  = r_row_cnt + C_ONE;

    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= S_IDLE;
            r_rows             <= '0;
            r_cols             <= '0;
            r_row_cnt          <= '0;
            r_col_cnt          <= '0;
            cmd_ready          <= 1'b0;
            done               <= 1'b0;
            done_err           <= 1'b0;
            extra_fetch_err    <= 1'b0;
            job_start          <= 1'b0;
            job_fetch_ack      <= 1'b0;
            job_fetch_complete <= 1'b0;
            job_complete_ack   <= 1'b0;
        end else begin
            done               <= 1'b0;
            done_err           <= 1'b0;
            job_fetch_ack      <= 1'b0;
            job_fetch_complete <= 1'b0;
            job_complete_ack   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        r_rows          <= cmd_num_rows;
                        r_cols          <= cmd_num_cols;
                        r_row_cnt       <= '0;
                        r_col_cnt       <= '0;
                        extra_fetch_err <= 1'b0;
                        // Degenerate jobs are answered locally; the quad never sees them.
                        if (cmd_num_rows == '0 || cmd_num_cols == '0) begin
                            done     <= 1'b1;
                            done_err <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            job_start <= 1'b1;
                            r_state   <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (job_accept) begin
                        job_start <= 1'b0;
                        r_state   <= S_WAIT_REQ;
                    end
                end
                S_WAIT_REQ: begin
                    if (job_fetch_request) begin
                        job_fetch_ack <= 1'b1;
                        r_state       <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_beat) begin
                        if (r_col_cnt == r_cols - C_ONE) begin
                            r_col_cnt          <= '0;
                            job_fetch_complete <= 1'b1;
                            r_state            <= S_FCOMP;
                        end else begin
                            r_col_cnt <= r_col_cnt + C_ONE;
                        end
                    end
                end
                S_FCOMP: begin
                    r_row_cnt <= w_row_next;
                    r_state   <= (w_row_next == r_rows) ? S_WAIT_DONE : S_WAIT_REQ;
                end
                S_WAIT_DONE: begin
                    if (job_fetch_request) begin
                        extra_fetch_err <= 1'b1;
                    end
                    if (job_complete) begin
                        job_complete_ack <= 1'b1;
                        done             <= 1'b1;
                        r_state          <= S_CACK;
                    end
                end
                S_CACK: begin
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
